// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
package bsearch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  // Widest supported result; bounds live in WIDTH+1 bits, so the helper works at MAX_WIDTH+1.
  localparam int MAX_WIDTH = 16;

  // Step counter width: $clog2(w), but never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Midpoint of [b, e); the sum carries one extra bit so it cannot overflow.
  function automatic logic [MAX_WIDTH:0] midpoint(input logic [MAX_WIDTH:0] b,
                                                  input logic [MAX_WIDTH:0] e);
    logic [MAX_WIDTH+1:0] sum;
    sum = {1'b0, b} + {1'b0, e};
    return (MAX_WIDTH+1)'(sum >> 1);
  endfunction

endpackage

// File: rtl/param_binary_search.sv
// One-shot binary search for the largest X with target >= X; WIDTH probes, done pulses WIDTH+1 cycles after start.
// Start is ignored while busy; define BSEARCH_INT_CMP_EN to compare against v_in internally instead of the ge input.
module param_binary_search
  import bsearch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BSEARCH_INT_CMP_EN
  input  logic [WIDTH-1:0] v_in,
`else
  input  logic             ge,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] probe,
  output logic             done,
  output logic [WIDTH-1:0] ans
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [WIDTH:0]  E_INIT   = (WIDTH+1)'(1) << WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  state_t             state, state_nxt;
  logic [WIDTH:0]     b_q, e_q, m;
  logic [CNT_W-1:0]   cnt_q;
  logic [MAX_WIDTH:0] m_full;
  logic               cmp_ge;
  logic               last;
  logic               unused_bits;

  // b < e is invariant, so m never reaches 2^WIDTH and fits the probe port.
  assign m_full      = midpoint((MAX_WIDTH+1)'(b_q), (MAX_WIDTH+1)'(e_q));
  assign m           = m_full[WIDTH:0];
  assign unused_bits = ^{m_full, b_q[WIDTH]};

`ifdef BSEARCH_INT_CMP_EN
  assign cmp_ge = (v_in >= probe);
`else
  assign cmp_ge = ge;
`endif

  assign busy  = (state == SEARCH);
  assign probe = busy ? m[WIDTH-1:0] : '0;
  assign last  = (cnt_q == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      b_q   <= '0;
      e_q   <= E_INIT;
      cnt_q <= '0;
      ans   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= busy && last;
      if (state == IDLE && start) begin
        b_q   <= '0;
        e_q   <= E_INIT;
        cnt_q <= '0;
      end else if (busy) begin
        if (cmp_ge) b_q <= m;
        else        e_q <= m;
        cnt_q <= cnt_q + CNT_W'(1);
        // On the final probe the answer is m if it passed, else the last passing bound.
        if (last) ans <= cmp_ge ? m[WIDTH-1:0] : b_q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_param_binary_search.sv
// Self-checking bench: table-driven searches with a done/ans scoreboard, plus corner sequences.
module tb_param_binary_search;

  logic        clk = 1'b0;
  logic        rst, start, start1, start16;
  logic [7:0]  target;
  logic        t1;
  logic [15:0] t16;
  int          mode;

  logic        busy, done, busy1, done1, busy16, done16;
  logic [7:0]  probe, ans;
  logic        probe1, ans1;
  logic [15:0] probe16, ans16;

  always #5 clk = ~clk;

`ifndef BSEARCH_INT_CMP_EN
  // Sorted-table comparator model: mode 0 compares, 1 forces 0, 2 forces 1.
  logic ge, ge1, ge16;
  assign ge   = (mode == 0) ? (target >= probe) : (mode == 2);
  assign ge1  = (t1 >= probe1);
  assign ge16 = (t16 >= probe16);
`endif

  param_binary_search #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef BSEARCH_INT_CMP_EN
    .v_in(target),
`else
    .ge(ge),
`endif
    .busy(busy), .probe(probe), .done(done), .ans(ans));

  param_binary_search #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef BSEARCH_INT_CMP_EN
    .v_in(t1),
`else
    .ge(ge1),
`endif
    .busy(busy1), .probe(probe1), .done(done1), .ans(ans1));

  param_binary_search #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst(rst), .start(start16),
`ifdef BSEARCH_INT_CMP_EN
    .v_in(t16),
`else
    .ge(ge16),
`endif
    .busy(busy16), .probe(probe16), .done(done16), .ans(ans16));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] ans;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every done pulse must match the oldest outstanding search.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ans", ans, e.ans);
        check("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  // Caller sits at a negedge; start is sampled at the next edge k, done expected k+8 edges later.
  task automatic kick(input logic [7:0] exp_ans);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{ans: exp_ans, done_cyc: cyc + 8});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  typedef struct {
    logic [7:0] tgt;
    int         md;
    logic [7:0] exp_ans;
  } vec_t;

  vec_t vt[9];
  int   pl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd173, 0, 8'd173};
    vt[1] = '{8'd0,   0, 8'd0};
    vt[2] = '{8'd255, 0, 8'd255};
    vt[3] = '{8'd90,  0, 8'd90};
    vt[4] = '{8'd1,   0, 8'd1};
    vt[5] = '{8'd128, 0, 8'd128};
    vt[6] = '{8'd127, 0, 8'd127};
    vt[7] = '{8'd90,  1, 8'd0};
    vt[8] = '{8'd0,   2, 8'd255};
    pl = '{128, 192, 160, 176, 168, 172, 174, 173};

    rst = 1'b1; start = 1'b0; start1 = 1'b0; start16 = 1'b0;
    target = '0; t1 = 1'b0; t16 = '0; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_probe", probe, 0);
    check("rst_ans", ans, 0);
    check("rst_ans_w16", ans16, 0);
    rst = 1'b0;

    // Probe sequence for target 173.
    @(negedge clk);
    target = 8'd173;
    kick(8'd173);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("seq_busy", busy, 1);
      check("seq_probe", probe, pl[i]);
    end
    wait_idle();
    check("seq_idle_busy", busy, 0);
    check("seq_idle_probe", probe, 0);

    for (int i = 0; i < 9; i++) begin
`ifdef BSEARCH_INT_CMP_EN
      if (vt[i].md != 0) continue;
`endif
      @(negedge clk);
      target = vt[i].tgt;
      mode   = vt[i].md;
      kick(vt[i].exp_ans);
      wait_idle();
    end
    mode = 0;

    // start held high during cycles k+2..k+5 of a search is ignored.
    @(negedge clk);
    target = 8'd60;
    kick(8'd60);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_while_restart", busy, 1);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("ignored_start_idle", busy, 0);

    // start accepted on the done cycle.
    @(negedge clk);
    target = 8'd200;
    kick(8'd200);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
    target = 8'd33;
    kick(8'd33);
    check("restart_busy", busy, 1);
    check("restart_ans_held", ans, 200);
    wait_idle();

    // Reset in cycle k+4 aborts without a done pulse.
    @(negedge clk);
    target = 8'd150;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_probe", probe, 0);
    check("abort_ans", ans, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    target = 8'd77;
    kick(8'd77);
    wait_idle();

    // Width extremes: WIDTH=1 done at k+2, WIDTH=16 done at k+17.
    for (int r = 0; r < 2; r++) begin
      int c0, d1, d16;
      logic        e1;
      logic [15:0] e16;
      e1  = (r == 0) ? 1'b1 : 1'b0;
      e16 = (r == 0) ? 16'd40000 : 16'd65535;
      @(negedge clk);
      t1 = e1;
      t16 = e16;
      start1 = 1'b1;
      start16 = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start1 = 1'b0;
      start16 = 1'b0;
      d1 = -1;
      d16 = -1;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (done1 && d1 < 0) d1 = cyc;
        if (done16 && d16 < 0) d16 = cyc;
      end
      check("w1_ans", ans1, e1);
      check("w1_done_cycle", d1, c0 + 1);
      check("w16_ans", ans16, e16);
      check("w16_done_cycle", d16, c0 + 16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_binary_search.md
Name: param_binary_search

Overview:
- Parametrised successive-approximation (binary) search engine with start/busy/done handshake.
- Finds the largest value X in [0, 2^WIDTH-1] for which a monotonic comparison "target >= X" holds.
- The comparison is external by default: `probe` out, `ge` in. This lets the block search a sorted table or drive a SAR-style comparator.
- Replaces free-running fixed-8-bit searches with a one-shot, restartable, width-generic engine.

Parameters:
- WIDTH, 8, result/probe width; legal range 1..16; search space is 0..2^WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new search; sampled only in IDLE.
- ge  in  1  comparison result for the current probe: 1 = target >= probe. Sampled every SEARCH cycle. Absent when BSEARCH_INT_CMP_EN is defined.
- busy  out  1  high while in SEARCH.
- probe  out  WIDTH  current midpoint under test; 0 outside SEARCH.
- done  out  1  one-cycle pulse; ans is valid from this cycle on.
- ans  out  WIDTH  last completed result; held until the next completion.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, probe=0, ans=0; b=0, e=2^WIDTH, cnt=0.
- Reset mid-search aborts immediately; no done pulse.
- Internal registers:
  - b, e: WIDTH+1 bits.
  - m = (b+e)>>1, with the sum formed at WIDTH+2 bits so there is no overflow.
  - Invariant b<e, so m <= 2^WIDTH-1 always; probe = m[WIDTH-1:0].
- States: IDLE, SEARCH.
  - IDLE, start=1: b<=0, e<=2^WIDTH, cnt<=0, go SEARCH.
  - IDLE, start=0: stay.
  - SEARCH, each cycle:
    - if ge, b<=m, else e<=m; cnt<=cnt+1.
    - On the cycle with cnt==WIDTH-1: ans<=(ge ? m : b), done<=1, go IDLE.
  - done is registered; it is high exactly one cycle, while the state is already IDLE.
- Latency: start sampled at edge k → SEARCH occupies cycles k+1..k+WIDTH (exactly WIDTH probes) → done=1 and new ans visible in cycle k+WIDTH+1. Fixed; independent of data.
- start while busy: ignored, no queueing.
- start in the cycle done is high: accepted (state is IDLE); busy rises next cycle; ans keeps its new value.
- ge assumed monotonic (1 for all probes <= target). Non-monotonic ge still terminates in WIDTH cycles with an unspecified but in-range result.
- Degenerate results:
  - ge=0 for every probe → ans=0.
  - ge=1 for every probe → ans=2^WIDTH-1.
- WIDTH=1: a single probe of value 1; ans=ge.

Optional Feature:
- Macro BSEARCH_INT_CMP_EN.
- Defined:
  - ge port removed; input v_in [WIDTH-1:0] added.
  - ge computed internally as (v_in >= probe).
  - v_in must be held stable during SEARCH; the result equals v_in.
  - Drop-in self-test/quantiser mode.
- Undefined: external ge port as above; no v_in.
- All timing is identical in both builds.

Decomposition:
- Package bsearch_pkg holds:
  - state enum type (IDLE, SEARCH);
  - function midpoint(b,e) returning (b+e)>>1;
  - constant for counter width, $clog2(WIDTH) with minimum 1.
- No sub-module: the FSM and the 3-register datapath are small enough to stay in one module.

Test Plan:
- INT_CMP build, WIDTH=8, v_in=173, start pulse at edge k:
  - probes 128,192,160,176,168,172,174,173;
  - done only in cycle k+9, ans=173; busy high cycles k+1..k+8.
- INT_CMP build, v_in=0 then v_in=255 → ans=0 and ans=255 respectively. Probe never exceeds 255 and never reads 256.
- External ge from sorted-table model (target 90 vs probes), WIDTH=8 → ans=90. Then ge forced 0 always → ans=0.
- start re-pulsed during cycles k+2..k+5 → ignored; single done at k+9. start asserted on the done cycle → new search begins, done again 9 cycles later.
- rst asserted in cycle k+4 of a search → next cycle busy=0, probe=0, ans=0; no done pulse. Fresh start afterwards completes normally.
- WIDTH=1 and WIDTH=16 builds, INT_CMP, v_in=1 / v_in=40000 → ans matches; done at k+2 / k+17.
